uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
// - Shares the single UART transmitter among NumReq byte-stream requesters (debug console, CPU, DMA...).
// - Grants one requester at a time, round-robin. Holds the grant for a whole message, i.e. until the
//   byte flagged last, or until the requester stalls for LockTimeout cycles.
// - Writes each byte into THR with a one-cycle write strobe. Paces the writes off the LSR THR-empty
//   flag, so the TX FIFO / THR never overflows.
//
// PARAMETERS
// - NumReq      4    number of requesters, 2..16
// - LockTimeout 256  idle cycles a granted requester may stall before its lock is dropped, >=2
// - IdW         $clog2(NumReq)  derived, width of the grant index; do not override
//
// PORTS
// - clk_i        in   1          single clock
// - rst_i        in   1          asynchronous, active-high reset
// - req_valid_i  in   NumReq     requester r presents a byte
// - req_data_i   in   NumReq*8   byte of requester r at [8r+:8]
// - req_last_i   in   NumReq     byte is the final one of a message
// - req_ready_o  out  NumReq     byte accepted when valid & ready; one-hot or zero
// - thr_empty_i  in   1          LSR THR-empty; with the FIFO enabled, high = FIFO empty
// - thr_we_o     out  1          registered one-cycle THR write strobe
// - thr_wdata_o  out  8          registered THR write data, valid with thr_we_o
// - grant_id_o   out  IdW        index of the current owner; holds the last owner when idle
// - busy_o       out  1          a lock is held
//
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, round-robin pointer = NumReq-1 (requester 0 wins first),
//   guard and timeout counters 0.
// - Asserting reset mid-message drops any pending strobe. The interrupted message is not resumed.
// - FSM states: IDLE, TAG (only with the macro), LOCK.
// - IDLE -> LOCK
//   - Triggers when any req_valid_i is high.
//   - Winner is the first valid index after the pointer, searching upward with wrap.
//   - grant_id_o and busy_o update on the next edge. No byte is accepted in the arbitration cycle.
// - LOCK, ready:
//   - req_ready_o[grant] = thr_empty_i & (guard==0); all other readys are 0.
//   - Other requesters are ignored while locked, even if their valid is high.
// - LOCK, transfer at cycle t:
//   - thr_we_o=1 and thr_wdata_o=byte at t+1, exactly one cycle.
//   - The guard is loaded with 2 at t+1 and decrements to 0. Ready stays low t+1..t+2, because the LSR
//     flag lags the strobe.
//   - Net result: at most one byte every 3 cycles.
// - LOCK -> IDLE on a transfer with req_last_i=1. The pointer is set to the owner.
// - Timeout:
//   - The counter increments each LOCK cycle with req_valid_i[grant]=0 and clears on every transfer.
//   - At LockTimeout-1 it releases to IDLE, with the pointer set to the owner.
//   - Cycles where valid=1 but thr_empty_i=0 do not count.
// - Lock persistence: a requester deasserting valid mid-message keeps the lock until timeout.
// - Simultaneous last-transfer and new valids: the release takes priority. The next arbitration happens
//   in IDLE on the following cycle, and the previous owner is lowest priority there.
// - thr_empty_i stuck low: the lock is held indefinitely (no timeout) and no strobe is issued.
//
// CONFIGURATION
// - UART_TX_ARB_TAG_EN defined:
//   - IDLE -> TAG on grant.
//   - TAG emits the tag byte 8'hF0 | grant with the same thr_empty_i/guard rules and no requester
//     handshake, then -> LOCK.
//   - Lets the receiver demultiplex messages.
// - Undefined: no TAG state; IDLE -> LOCK directly, and the byte stream is unmodified.
//
// TESTING
// - Reset, then req0 sends 3 bytes 0x41,0x42,0x43(last), thr_empty_i=1
//   -> thr_we_o pulses carry 0x41, 0x42, 0x43 spaced 3 cycles apart; busy_o falls after 0x43.
// - req1 and req3 valid together after reset, each 1-byte last
//   -> req1 is served first, then req3; grant_id_o is 1 then 3.
// - req2 mid-message drops valid for LockTimeout cycles
//   -> lock released; a waiting req0 is granted; no strobe during the stall.
// - thr_empty_i held 0 for 50 cycles while req0 is valid
//   -> req_ready_o=0, no strobe, no timeout; the byte is sent 1 cycle after thr_empty_i rises.
// - rst_i asserted in the cycle after a transfer
//   -> thr_we_o=0 immediately, busy_o=0, requester 0 has priority next.
// - With UART_TX_ARB_TAG_EN, req3 sends 0x55(last)
//   -> strobes carry 0xF3 then 0x55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART THR among NumReq byte-stream requesters.
// Optional macro UART_TX_ARB_TAG_EN prefixes every message with the tag byte 8'hF0 | grant.
module uart_tx_arbiter #(
    parameter int NumReq      = 4,
    parameter int LockTimeout = 256,
    parameter int IdW         = $clog2(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [NumReq*8-1:0] req_data_i,
    input  logic [NumReq-1:0]   req_last_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  logic                thr_empty_i,
    output logic                thr_we_o,
    output logic [7:0]          thr_wdata_o,
    output logic [IdW-1:0]      grant_id_o,
    output logic                busy_o
);
    localparam int              TmoW    = $clog2(LockTimeout);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(LockTimeout - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef UART_TX_ARB_TAG_EN
        TAG  = 2'd2,
`endif
        LOCK = 2'd1
    } state_t;

    state_t          state;
    logic [IdW-1:0]  ptr;
    logic [1:0]      guard;
    logic [TmoW-1:0] tmo;

    logic [IdW-1:0]  winner;
    logic            slot_free;
    logic            xfer;
    logic [7:0]      grant_data;

    // The LSR flag lags our own strobe, so a write slot also needs the guard to have run out.
    assign slot_free  = thr_empty_i && (guard == 2'd0);
    assign xfer       = (state == LOCK) && req_valid_i[grant_id_o] && slot_free;
    assign grant_data = req_data_i[{grant_id_o, 3'b000} +: 8];

    // Scanning from the farthest offset down leaves the nearest valid index after ptr as winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner = ptr;
        for (int i = NumReq; i >= 1; i--) begin
            if (req_valid_i[(int'(ptr) + i) % NumReq]) begin
                winner = IdW'((int'(ptr) + i) % NumReq);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == LOCK) begin
            req_ready_o[grant_id_o] = slot_free;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= IdW'(NumReq - 1);
            grant_id_o  <= '0;
            busy_o      <= 1'b0;
            thr_we_o    <= 1'b0;
            thr_wdata_o <= '0;
            guard       <= '0;
            tmo         <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state; later assignments in this block
            // override the defaults below (single-cycle strobe, free-running guard decrement).
            thr_we_o <= 1'b0;
            if (guard != 2'd0) begin
                guard <= guard - 2'd1;
            end

            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        grant_id_o <= winner;
                        busy_o     <= 1'b1;
                        tmo        <= '0;
`ifdef UART_TX_ARB_TAG_EN
                        state      <= TAG;
`else
                        state      <= LOCK;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                TAG: begin
                    if (slot_free) begin
                        thr_we_o    <= 1'b1;
                        thr_wdata_o <= 8'hF0 | 8'(grant_id_o);
                        guard       <= 2'd2;
                        state       <= LOCK;
                    end
                end
`endif
                LOCK: begin
                    if (xfer) begin
                        thr_we_o    <= 1'b1;
                        thr_wdata_o <= grant_data;
                        guard       <= 2'd2;
                        tmo         <= '0;
                        if (req_last_i[grant_id_o]) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            ptr    <= grant_id_o;
                        end
                    end else if (!req_valid_i[grant_id_o]) begin
                        // Only a silent owner ages the lock; waiting on THR never does.
                        if (tmo == TmoLast) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            ptr    <= grant_id_o;
                            tmo    <= '0;
                        end else begin
                            tmo <= tmo + TmoW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios and randomized message traffic checked against
// a queue-based round-robin message model; tag bytes are expected when UART_TX_ARB_TAG_EN is set.
module tb_uart_tx_arbiter;
    localparam int NUM = 4;
    localparam int TMO = 16;
    localparam int IDW = $clog2(NUM);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NUM-1:0]   req_valid_i;
    logic [NUM*8-1:0] req_data_i;
    logic [NUM-1:0]   req_last_i;
    logic [NUM-1:0]   req_ready_o;
    logic             thr_empty_i;
    logic             thr_we_o;
    logic [7:0]       thr_wdata_o;
    logic [IDW-1:0]   grant_id_o;
    logic             busy_o;

    uart_tx_arbiter #(.NumReq(NUM), .LockTimeout(TMO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .thr_empty_i (thr_empty_i),
        .thr_we_o    (thr_we_o),
        .thr_wdata_o (thr_wdata_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Every THR write seen on the bus, with its owner and the cycle it appeared in.
    logic [IDW+7:0] strobe_q[$];
    int             strobe_cyc[$];
    always @(negedge clk_i) begin
        if (thr_we_o) begin
            strobe_q.push_back({grant_id_o, thr_wdata_o});
            strobe_cyc.push_back(cyc);
        end
    end

`ifdef UART_TX_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic [8:0]     src_q [NUM][$];   // {last, data} still to be offered by each requester
    logic [IDW+7:0] exp_q[$];         // expected {owner, byte} stream
    int             mdl_ptr;
    int             n_cmp = 0;
    int             n_err = 0;
    int             onehot_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        thr_empty_i = 1'b1;
        step(2);
        strobe_q.delete();
        strobe_cyc.delete();
        rst_i   = 1'b0;
        mdl_ptr = NUM - 1;
    endtask

    task automatic push(input int r, input logic [7:0] data, input bit last);
        src_q[r].push_back({last, data});
    endtask

    // Whole messages are handed out round-robin, starting after the previous owner.
    task automatic build_expected();
        logic [8:0] mq [NUM][$];
        logic [8:0] b;
        int owner;
        for (int r = 0; r < NUM; r++) mq[r] = src_q[r];
        exp_q.delete();
        forever begin
            owner = -1;
            for (int i = 1; i <= NUM; i++) begin
                if (owner < 0 && mq[(mdl_ptr + i) % NUM].size() != 0) owner = (mdl_ptr + i) % NUM;
            end
            if (owner < 0) break;
            if (TAG_ON) exp_q.push_back({IDW'(owner), 8'hF0 | 8'(owner)});
            do begin
                b = mq[owner].pop_front();
                exp_q.push_back({IDW'(owner), b[7:0]});
            end while (!b[8] && mq[owner].size() != 0);
            mdl_ptr = owner;
        end
    endtask

    task automatic compare_strobes(input string tag);
        check({tag, "_count"}, strobe_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(strobe_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic wait_accept(input int r, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            got = req_valid_i[r] && req_ready_o[r];
            @(posedge clk_i);
            #1;
        end
        check(tag, got, 1);
    endtask

    // Drives all queued messages at once and compares the THR stream against the model.
    task automatic run_traffic(input string tag, input bit rand_empty, input int budget);
        logic [NUM-1:0] acc;
        int  n    = 0;
        bit  pend = 1'b1;
        build_expected();
        while (pend && n < budget) begin
            for (int r = 0; r < NUM; r++) begin
                req_valid_i[r] = (src_q[r].size() != 0);
                if (src_q[r].size() != 0) begin
                    req_data_i[8*r +: 8] = src_q[r][0][7:0];
                    req_last_i[r]        = src_q[r][0][8];
                end
            end
            thr_empty_i = rand_empty ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk_i);
            acc = req_valid_i & req_ready_o;
            if ($countones(req_ready_o) > 1) onehot_err++;
            @(posedge clk_i);
            #1;
            pend = 1'b0;
            for (int r = 0; r < NUM; r++) begin
                if (acc[r]) void'(src_q[r].pop_front());
                if (src_q[r].size() != 0) pend = 1'b1;
            end
            n++;
        end
        req_valid_i = '0;
        req_last_i  = '0;
        thr_empty_i = 1'b1;
        step(4);
        check({tag, "_done"}, n < budget, 1);
        compare_strobes(tag);
        for (int i = 1; i < strobe_cyc.size(); i++) begin
            if (rand_empty) check($sformatf("%s_gap%0d", tag, i), (strobe_cyc[i] - strobe_cyc[i-1]) >= 3, 1);
            else            check($sformatf("%s_gap%0d", tag, i), strobe_cyc[i] - strobe_cyc[i-1], 3);
        end
        check({tag, "_idle"}, busy_o, 0);
        strobe_q.delete();
        strobe_cyc.delete();
    endtask

    initial begin
        int nm;
        int len;
        int c0;
        int stall_bad;

        // Reset values, then one arbitration cycle with everybody valid.
        rst_i       = 1'b1;
        req_valid_i = '1;
        req_last_i  = '0;
        req_data_i  = '0;
        thr_empty_i = 1'b1;
        step(2);
        check("rst_we", thr_we_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_grant", grant_id_o, 0);
        check("rst_ready", req_ready_o, 0);
        rst_i = 1'b0;
        #1;
        check("arb_cycle_no_ready", req_ready_o, 0);
        step(1);
        check("first_grant_req0", grant_id_o, 0);
        check("first_grant_busy", busy_o, 1);
        check("first_grant_no_we", thr_we_o, 0);

        // req0 sends a three-byte message.
        do_reset();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        run_traffic("req0_msg", 1'b0, 100);

        // req1 and req3 collide right after reset.
        do_reset();
        push(1, 8'hB1, 1'b1);
        push(3, 8'hD3, 1'b1);
        run_traffic("rr_1_3", 1'b0, 100);

        // Randomized messages, alternating steady and flickering THR-empty.
        do_reset();
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < NUM; r++) begin
                if (r == 0 || $urandom_range(0, 3) != 0) begin
                    nm = $urandom_range(1, 3);
                    for (int m = 0; m < nm; m++) begin
                        len = $urandom_range(1, 4);
                        for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                    end
                end
            end
            run_traffic($sformatf("rand%0d", round), round[0], 600);
        end

        // req2 stalls mid-message long enough to lose its lock while req0 waits.
        do_reset();
        req_valid_i = 4'b0100;
        req_data_i[23:16] = 8'h21;
        wait_accept(2, "tmo_req2_accept");
        req_valid_i = 4'b0001;
        req_data_i[7:0] = 8'h0A;
        req_last_i = 4'b0001;
        step(TMO - 1);
        check("tmo_busy_held", busy_o, 1);
        check("tmo_grant_held", grant_id_o, 2);
        step(1);
        check("tmo_released", busy_o, 0);
        check("tmo_no_stall_strobe", strobe_q.size(), TAG_ON ? 2 : 1);
        wait_accept(0, "tmo_req0_accept");
        check("tmo_req0_grant", grant_id_o, 0);
        req_valid_i = '0;
        req_last_i  = '0;
        step(3);
        exp_q.delete();
        if (TAG_ON) exp_q.push_back({IDW'(2), 8'hF2});
        exp_q.push_back({IDW'(2), 8'h21});
        if (TAG_ON) exp_q.push_back({IDW'(0), 8'hF0});
        exp_q.push_back({IDW'(0), 8'h0A});
        compare_strobes("tmo");

        // THR busy for 50 cycles: no ready, no strobe, no timeout.
        do_reset();
        thr_empty_i = 1'b0;
        req_valid_i = 4'b0001;
        req_data_i[7:0] = 8'h5A;
        req_last_i = 4'b0001;
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (req_ready_o != '0 || thr_we_o) stall_bad++;
        end
        check("thr_full_quiet", stall_bad, 0);
        check("thr_full_busy_held", busy_o, 1);
        thr_empty_i = 1'b1;
        c0 = cyc;
        wait_accept(0, "thr_full_accept");
        req_valid_i = '0;
        req_last_i  = '0;
        step(4);
        check("thr_full_first_cyc", strobe_cyc.size() != 0 ? strobe_cyc[0] : -1, c0 + 1);
        check("thr_full_first_byte", strobe_q.size() != 0 ? 32'(strobe_q[0]) : 32'hFFFF,
              {IDW'(0), TAG_ON ? 8'hF0 : 8'h5A});
        check("thr_full_idle", busy_o, 0);
        strobe_q.delete();
        strobe_cyc.delete();

        // Reset right after a transfer of req1, with req0 as previous owner.
        do_reset();
        push(0, 8'h01, 1'b1);
        run_traffic("pre_rst", 1'b0, 100);
        req_valid_i = 4'b0010;
        req_data_i[15:8] = 8'h11;
        wait_accept(1, "rst_mid_accept");
        check("rst_mid_we_before", thr_we_o, 1);
        check("rst_mid_data_before", thr_wdata_o, 8'h11);
        rst_i = 1'b1;
        #1;
        check("rst_mid_we", thr_we_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_grant", grant_id_o, 0);
        step(1);
        rst_i       = 1'b0;
        req_valid_i = '0;
        strobe_q.delete();
        strobe_cyc.delete();
        mdl_ptr = NUM - 1;
        push(1, 8'h12, 1'b1);
        push(0, 8'h02, 1'b1);
        run_traffic("after_rst", 1'b0, 100);

`ifdef UART_TX_ARB_TAG_EN
        do_reset();
        push(3, 8'h55, 1'b1);
        run_traffic("tag_req3", 1'b0, 100);
`endif

        check("ready_onehot", onehot_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
